alu_cmd_sequencer: RTL and testbench

Initiator-side controller for the team's 4-bit combinational ALU. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU operand and opcode inputs from registers, samples the ALU result and flags, and returns one response per command over a second valid/ready interface. It sits between a command source (testbench, microcontroller core or UART front end) and the ALU instance.

---
 rtl/alu_cmd_sequencer_if.sv | 28 ++
 rtl/alu_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels between a command source and alu_cmd_sequencer.
// The master modport is the command source; the slave modport is the sequencer.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_chain;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_parity;
    logic [2:0] rsp_op;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_parity, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_parity, rsp_op
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// FIFO-buffered command sequencer driving a 4-bit combinational ALU, one response per command.
// Define ALU_SEQ_CHAIN_EN to let a command take its operand a from the previous result.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [2:0]          alu_s,
    input  logic [3:0]          alu_result,
    input  logic                alu_carryout,
    input  logic                alu_zero,
    input  logic                alu_parity,
    output logic [AW:0]         fifo_level,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
        logic       chain;
`endif
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } entry_t;

    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [3:0]    alu_a_q, alu_a_d;
    logic [3:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_s_q, alu_s_d;
    logic [3:0]    rsp_result_q, rsp_result_d;
    logic          rsp_carry_q, rsp_carry_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_parity_q, rsp_parity_d;
    logic [2:0]    rsp_op_q, rsp_op_d;
`ifdef ALU_SEQ_CHAIN_EN
    logic [3:0]    last_result_q, last_result_d;
`endif

    entry_t fifo_mem [DEPTH];
    entry_t wr_entry;
    entry_t rd_entry;
    logic   cmd_ready_int;
    logic   push;
    logic   pop;

    assign cmd_ready_int = (level_q != LEVEL_FULL);
    assign push          = bus.cmd_valid && cmd_ready_int;
    assign rd_entry      = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_entry    = '0;
        wr_entry.op = bus.cmd_op;
        wr_entry.a  = bus.cmd_a;
        wr_entry.b  = bus.cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
        wr_entry.chain = bus.cmd_chain;
`endif
    end

`ifndef ALU_SEQ_CHAIN_EN
    // Chain request has no effect in this build.
    logic unused_cmd_chain;
    assign unused_cmd_chain = bus.cmd_chain;
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves a latch.
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d      = level_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_parity_d = rsp_parity_q;
        rsp_op_d     = rsp_op_q;
`ifdef ALU_SEQ_CHAIN_EN
        last_result_d = last_result_q;
`endif
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    alu_a_d  = rd_entry.a;
`ifdef ALU_SEQ_CHAIN_EN
                    if (rd_entry.chain) alu_a_d = last_result_q;
`endif
                    alu_b_d  = rd_entry.b;
                    alu_s_d  = rd_entry.op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Carry is only meaningful for add; other ops report 0.
                rsp_result_d = alu_result;
                rsp_carry_d  = (alu_s_q == 3'b000) ? alu_carryout : 1'b0;
                rsp_zero_d   = alu_zero;
                rsp_parity_d = alu_parity;
                rsp_op_d     = alu_s_q;
`ifdef ALU_SEQ_CHAIN_EN
                last_result_d = alu_result;
`endif
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_parity_q <= 1'b0;
            rsp_op_q     <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            last_result_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_parity_q <= rsp_parity_d;
            rsp_op_q     <= rsp_op_d;
`ifdef ALU_SEQ_CHAIN_EN
            last_result_q <= last_result_d;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_entry;
    end

    assign bus.cmd_ready  = cmd_ready_int;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_parity = rsp_parity_q;
    assign bus.rsp_op     = rsp_op_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_s          = alu_s_q;
    assign fifo_level     = level_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed commands, a behavioural ALU, and a response monitor.
// Chain expectations follow whether ALU_SEQ_CHAIN_EN is defined.
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] result;
        logic       carry;
        logic       zero;
        logic       parity;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_s;
    logic       alu_carryout, alu_zero, alu_parity;
    logic [2:0] fifo_level;
    logic       busy;
    logic [4:0] alu_sum;

    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;
    rsp_t exp_q[$];
    rsp_t cur_exp;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_s        (alu_s),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_parity   (alu_parity),
        .fifo_level   (fifo_level),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; carryout is deliberately 1 on non-add ops so the sequencer must mask it.
    always_comb begin
        alu_sum = 5'd0;
        case (alu_s)
            3'b000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: alu_sum = {1'b0, alu_a - alu_b};
            3'b010: alu_sum = {1'b0, alu_a & alu_b};
            3'b011: alu_sum = {1'b0, alu_a | alu_b};
            3'b100: alu_sum = {1'b0, alu_a ^ alu_b};
            3'b101: alu_sum = {1'b0, ~alu_a};
            3'b110: alu_sum = {1'b0, alu_a + 4'd1};
            default: alu_sum = {1'b0, alu_a - 4'd1};
        endcase
        alu_result   = alu_sum[3:0];
        alu_carryout = (alu_s == 3'b000) ? alu_sum[4] : 1'b1;
        alu_zero     = (alu_sum[3:0] == 4'd0);
        alu_parity   = ^alu_sum[3:0];
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Response monitor: every handshake is compared against the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got result 0x%0h op %0d with nothing expected",
                         bus.rsp_result, bus.rsp_op);
            end else begin
                check($sformatf("rsp%0d {op,result,c,z,p}", n_rsp),
                      16'({bus.rsp_op, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_parity}),
                      16'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain, input logic [3:0] er, input logic ec,
                         input logic ez, input logic ep);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_chain = chain;
        cur_exp       = '{op: op, result: er, carry: ec, zero: ez, parity: ep};
    endtask

    // One clock: handshake sampled mid-cycle, returns just after the rising edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = bus.cmd_valid && bus.cmd_ready;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(cur_exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain, input logic [3:0] er, input logic ec,
                         input logic ez, input logic ep);
        bit acc = 1'b0;
        drive(op, a, b, chain, er, ec, ez, ep);
        for (int i = 0; i < 40 && !acc; i++) step(acc);
        bus.cmd_valid = 1'b0;
        if (!acc) timeout("issue");
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        @(posedge clk);
        #1;
        if (!done) timeout(name);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmd_ready"}, 16'(bus.cmd_ready), 16'd1);
        check({tag, "_rsp_valid"}, 16'(bus.rsp_valid), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
        check({tag, "_fifo_level"}, 16'(fifo_level), 16'd0);
        check({tag, "_alu_regs"}, 16'({alu_a, alu_b, alu_s}), 16'd0);
        check({tag, "_rsp_regs"}, 16'({bus.rsp_op, bus.rsp_result, bus.rsp_carry,
                                       bus.rsp_zero, bus.rsp_parity}), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int n_bp;
        int rsp_before;
        logic [2:0] bp_op [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [3:0] bp_a  [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [3:0] bp_res[6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        logic       bp_par[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        #1;

        // Add with carry out, and first-response latency.
        bus.rsp_ready = 1'b1;
        drive(3'b000, 4'd9, 4'd8, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
        step(acc);
        bus.cmd_valid = 1'b0;
        check("t1_accepted", 16'(acc), 16'd1);
        @(negedge clk);
        check("t1_level_after_push", 16'(fifo_level), 16'd1);
        check("t1_no_rsp_T", 16'(bus.rsp_valid), 16'd0);
        @(negedge clk);
        check("t1_exec_busy", 16'(busy), 16'd1);
        check("t1_no_rsp_T1", 16'(bus.rsp_valid), 16'd0);
        check("t1_alu_inputs", 16'({alu_a, alu_b, alu_s}), 16'({4'd9, 4'd8, 3'b000}));
        @(negedge clk);
        check("t1_rsp_T2", 16'(bus.rsp_valid), 16'd1);
        wait_drain("t1_drain");

        // Sub with borrow (carry masked) then xor to zero.
        issue(3'b001, 4'd3, 4'd5, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1);
        issue(3'b100, 4'd5, 4'd5, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        wait_drain("t2_drain");

        // Or, not, and decrement of zero with b ignored.
        issue(3'b011, 4'd4, 4'd2, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        issue(3'b101, 4'd5, 4'd9, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
        issue(3'b111, 4'd0, 4'd5, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        wait_drain("t3_drain");

        // Chained increment.
        issue(3'b110, 4'd7, 4'd0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
`ifdef ALU_SEQ_CHAIN_EN
        issue(3'b110, 4'd0, 4'd0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
`else
        issue(3'b110, 4'd0, 4'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
`endif
        wait_drain("chain_drain");

        // Backpressure: six back-to-back commands, five fit (one in flight plus DEPTH queued).
        bus.rsp_ready = 1'b0;
        n_bp = 0;
        for (int i = 0; i < 6; i++) begin
            drive(bp_op[i], bp_a[i], 4'd1, 1'b0, bp_res[i], 1'b0, 1'b0, bp_par[i]);
            step(acc);
            if (acc) n_bp++;
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 16'(n_bp), 16'd5);
        @(negedge clk);
        check("bp_cmd_ready_low", 16'(bus.cmd_ready), 16'd0);
        check("bp_level_full", 16'(fifo_level), 16'd4);
        check("bp_rsp_held", 16'({bus.rsp_valid, bus.rsp_result}), 16'({1'b1, 4'd2}));
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
        end
        check("bp_cmd_ready_back", 16'(acc), 16'd1);
        check("bp_level_after_pop", 16'(fifo_level), 16'd3);
        @(posedge clk);
        #1;
        wait_drain("bp_drain");

        // Reset while executing with two commands queued.
        bus.rsp_ready = 1'b0;
        issue(3'b000, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        issue(3'b010, 4'd15, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.rsp_valid;
        end
        check("rst_reached_resp", 16'(acc), 16'd1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drive(3'b011, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        step(acc);
        drive(3'b100, 4'd6, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step(acc);
        bus.cmd_valid = 1'b0;
        check("rst_pre_exec", 16'({busy, fifo_level}), 16'({1'b1, 3'd2}));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_zero_outputs("rst_mid");
        rsp_before = n_rsp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_stale_rsp", 16'(n_rsp - rsp_before), 16'd0);
        check("rst_idle_after", 16'({busy, fifo_level}), 16'd0);
        issue(3'b010, 4'd12, 4'd10, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
        wait_drain("rst_new_drain");

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        check("total_responses", 16'(n_rsp), 16'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
